// File: rtl/gray_to_binary_seq_pkg.sv
// Shared constants for the sequential Gray-to-binary decoder.
package gray_to_binary_seq_pkg;

  localparam int GRAY_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gray_to_binary_seq.sv
// Sequential Gray-to-binary decoder: accepts one Gray word, walks an XOR
// chain MSB-first one bit per clock, then offers the binary result.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a word, in_ready high
// ST_CONV | decoding bit idx; exactly WIDTH edges, inputs ignored
// ST_DONE | result held on binary with out_valid high until out_ready
module gray_to_binary_seq
  import gray_to_binary_seq_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] binary,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] gray_r;
  logic [CNT_W-1:0] idx;
  logic             prev;
  logic             bit_d;

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Next binary bit: running XOR of all Gray bits from the MSB down to idx.
  assign bit_d = gray_r[idx] ^ prev;

  // FSM, index counter and bit-serial result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      gray_r <= '0;
      idx    <= '0;
      prev   <= 1'b0;
      binary <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            gray_r <= gray;
            idx    <= CNT_W'(WIDTH - 1);
            prev   <= 1'b0;
            state  <= ST_CONV;
          end
        end
        ST_CONV: begin
          binary[idx] <= bit_d;
          prev        <= bit_d;
          // Terminal test on zero keeps idx from wrapping.
          if (idx == '0) begin
            state <= ST_DONE;
          end else begin
            idx <= idx - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
